// File: rtl/lsu_pkg.sv
// Shared load/store unit types: region decode, access size encodings and FSM states.
package lsu_pkg;

  typedef enum logic [1:0] {
    DMEM = 2'd0,
    OUT  = 2'd1,
    IN   = 2'd2,
    NONE = 2'd3
  } region_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam int IO_MAX = 64;

  function automatic region_e decode_region(input logic [2:0] sel);
    region_e r;
    case (sel)
      3'b000, 3'b001, 3'b010, 3'b011: r = DMEM;
      3'b100:                         r = OUT;
      3'b101:                         r = IN;
      default:                        r = NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane store mask/data placement and load data extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wlane,
  output logic [31:0] rdata
);

  logic [31:0] shifted_s;

  assign wlane     = wdata << {addr_lo, 3'b000};
  assign shifted_s = rword >> {addr_lo, 3'b000};

  // Store byte-enable mask for the addressed lanes
  always_comb begin
    be = 4'b0000;
    case (size[1:0])
      SZ_BYTE: be = 4'b0001 << addr_lo;
      SZ_HALF: be = 4'b0011 << {addr_lo[1], 1'b0};
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Load extraction: size[2] selects zero extension over sign extension
  always_comb begin
    rdata = 32'h0000_0000;
    case (size[1:0])
      SZ_BYTE: rdata = size[2] ? {24'h00_0000, shifted_s[7:0]}
                               : {{24{shifted_s[7]}}, shifted_s[7:0]};
      SZ_HALF: rdata = size[2] ? {16'h0000, shifted_s[15:0]}
                               : {{16{shifted_s[15]}}, shifted_s[15:0]};
      SZ_WORD: rdata = rword;
      default: rdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/lsu_param.sv
// Single-outstanding load/store unit over data memory, output registers and synchronized inputs.
// Define LSU_MISALIGN_ERR_EN to report misaligned half/word accesses instead of aligning them.
module lsu_param
  import lsu_pkg::*;
#(
  parameter int DMEM_WORDS = 256,
  parameter int N_OUT      = 11,
  parameter int N_IN       = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_size_i,
  input  logic [31:0]           req_addr_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_err_o,
  input  logic [32*N_IN-1:0]    io_in_i,
  output logic [32*N_OUT-1:0]   io_out_o
);

  localparam int AW    = $clog2(DMEM_WORDS);
  localparam int PAD_W = IO_MAX * 32;
  localparam logic [6:0] N_OUT_L = 7'(N_OUT);
  localparam logic [6:0] N_IN_L  = 7'(N_IN);

  state_e              state_r;
  logic [31:0]         rsp_rdata_r;
  logic                rsp_err_r;
  logic [32*N_OUT-1:0] out_r;
  logic [32*N_IN-1:0]  sync1_r;
  logic [32*N_IN-1:0]  sync2_r;
  logic [31:0]         dmem_r [DMEM_WORDS];

  logic [10:0]         addr_s;
  region_e             region_s;
  logic [5:0]          io_idx_s;
  logic [AW-1:0]       dmem_idx_s;
  logic                unmapped_s;
  logic                align_err_s;
  logic                err_s;
  logic                accept_s;
  logic                wr_dmem_s;
  logic                wr_out_s;
  logic [3:0]          be_s;
  logic [31:0]         wlane_s;
  logic [31:0]         rword_s;
  logic [31:0]         ldata_s;
  logic [PAD_W-1:0]    out_pad_s;
  logic [PAD_W-1:0]    in_pad_s;
  logic                unused_addr_s;

  assign unused_addr_s = ^req_addr_i[31:11];

  // Effective address: misaligned half/word accesses drop their low bits
  always_comb begin
    addr_s = req_addr_i[10:0];
    case (req_size_i[1:0])
      SZ_HALF: addr_s[0]   = 1'b0;
      SZ_WORD: addr_s[1:0] = 2'b00;
      default: addr_s      = req_addr_i[10:0];
    endcase
  end

`ifdef LSU_MISALIGN_ERR_EN
  assign align_err_s = ((req_size_i[1:0] == SZ_HALF) && req_addr_i[0]) ||
                       ((req_size_i[1:0] == SZ_WORD) && (req_addr_i[1:0] != 2'b00));
`else
  assign align_err_s = 1'b0;
`endif

  assign region_s   = decode_region(addr_s[10:8]);
  assign io_idx_s   = addr_s[7:2];
  assign dmem_idx_s = AW'({2'b00, addr_s[9:2]});
  assign out_pad_s  = PAD_W'(out_r);
  assign in_pad_s   = PAD_W'(sync2_r);

  // Region-dependent unmapped check and read-word selection
  always_comb begin
    unmapped_s = 1'b0;
    rword_s    = 32'h0000_0000;
    case (region_s)
      DMEM: begin
        unmapped_s = 1'b0;
        rword_s    = dmem_r[dmem_idx_s];
      end
      OUT: begin
        unmapped_s = ({1'b0, io_idx_s} >= N_OUT_L);
        rword_s    = out_pad_s[{io_idx_s, 5'b00000} +: 32];
      end
      IN: begin
        unmapped_s = ({1'b0, io_idx_s} >= N_IN_L);
        rword_s    = in_pad_s[{io_idx_s, 5'b00000} +: 32];
      end
      default: begin
        unmapped_s = 1'b1;
        rword_s    = 32'h0000_0000;
      end
    endcase
  end

  assign err_s = unmapped_s || align_err_s || (req_size_i[1:0] == SZ_ILL) ||
                 (req_we_i && (region_s == IN));

  assign accept_s  = req_valid_i && (state_r == ST_IDLE);
  assign wr_dmem_s = accept_s && req_we_i && !err_s && (region_s == DMEM);
  assign wr_out_s  = accept_s && req_we_i && !err_s && (region_s == OUT);

  lsu_align u_align (
    .size    (req_size_i),
    .addr_lo (addr_s[1:0]),
    .wdata   (req_wdata_i),
    .rword   (rword_s),
    .be      (be_s),
    .wlane   (wlane_s),
    .rdata   (ldata_s)
  );

  // Request/response handshake FSM; response captured at the acceptance edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= ST_IDLE;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r     <= ST_RESP;
            rsp_err_r   <= err_s;
            rsp_rdata_r <= (err_s || req_we_i) ? 32'h0000_0000 : ldata_s;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Output peripheral registers and the two-flop input synchronizer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_r   <= '0;
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= io_in_i;
      sync2_r <= sync1_r;
      for (int k = 0; k < N_OUT; k++) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_out_s && (io_idx_s == 6'(k)) && be_s[b]) begin
            out_r[32*k + 8*b +: 8] <= wlane_s[8*b +: 8];
          end
        end
      end
    end
  end

  // Data memory is intentionally not reset
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_dmem_s && be_s[b]) begin
        dmem_r[dmem_idx_s][8*b +: 8] <= wlane_s[8*b +: 8];
      end
    end
  end

  assign req_ready_o = (state_r == ST_IDLE);
  assign rsp_valid_o = (state_r == ST_RESP);
  assign rsp_rdata_o = rsp_rdata_r;
  assign rsp_err_o   = rsp_err_r;
  assign io_out_o    = out_r;

endmodule
